// File: rtl/mult_booth_if.sv
// Start/operand/result bundle between multdiv control and the Booth multiplier.
// master drives start and operands; slave returns product, overflow, ready and busy.
interface mult_booth_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/mult_booth.sv
// Multicycle signed WIDTHxWIDTH multiplier, radix-4 Booth, one recoded digit per cycle.
// Returns product[WIDTH-1:0] and a flag set when the full product overflows WIDTH signed bits.
module mult_booth #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 16
) (
    input logic          clock,
    input logic          reset,
    mult_booth_if.slave  bus
);
    localparam int unsigned UW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned CW = $clog2(STEPS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [UW-1:0]    m_q;
    logic [PW-1:0]    p_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic             start;
    logic             last_step;
    logic [2:0]       digit;
    logic [UW-1:0]    m2;
    logic [UW-1:0]    addend;
    logic             subtract;
    logic [UW-1:0]    u_new;
    logic signed [PW-1:0] p_cat;
    logic [PW-1:0]    p_shift;
    logic [UW-1:0]    prod_hi;

    assign last_step = (count_q == CW'(STEPS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start in DONE is accepted, a start in RUN is ignored
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.ctrl_MULT) begin
                    start   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.ctrl_MULT) begin
                    start   = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy           = (state_q == StRun);
        bus.data_resultRDY = (state_q == StDone);
        bus.data_result    = result_q;
        bus.data_exception = exc_q;
    end

    // Booth digit select and 33-bit add/sub
    always_comb begin
        digit    = p_q[2:0];
        m2       = {m_q[WIDTH-1:0], 1'b0};
        addend   = '0;
        subtract = 1'b0;
        case (digit)
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m2;
            3'b100: begin
                addend   = m2;
                subtract = 1'b1;
            end
            3'b101, 3'b110: begin
                addend   = m_q;
                subtract = 1'b1;
            end
            default: addend = '0;
        endcase
        u_new   = subtract ? (p_q[PW-1:UW] - addend) : (p_q[PW-1:UW] + addend);
        p_cat   = {u_new, p_q[UW-1:0]};
        p_shift = p_cat >>> 2;
        prod_hi = p_shift[PW-2:WIDTH];
    end

    // Datapath registers; result/flag captured on the edge that enters DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q      <= '0;
            p_q      <= '0;
            count_q  <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            m_q     <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
            p_q     <= {{UW{1'b0}}, bus.data_operandB, 1'b0};
            count_q <= '0;
        end else if (state_q == StRun) begin
            p_q     <= p_shift;
            count_q <= count_q + 1'b1;
            if (last_step) begin
                result_q <= p_shift[WIDTH:1];
                exc_q    <= ~(&prod_hi | ~|prod_hi);
            end
        end
    end
endmodule
